// File: rtl/rom_load_sched.sv
// Arbitrates the single-port ROM RAM between the HPS download stream and the
// game core's read port, and holds the core in reset across downloads.
module rom_load_sched #(
  parameter int ADDR_W      = 17,
  parameter int ROM_BYTES   = 98304,
  parameter int HOLD_CYCLES = 4096
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              core_rd,
  input  logic [ADDR_W-1:0] core_addr,
  output logic [7:0]        core_data,
  output logic              core_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout,
  output logic              core_reset,
  output logic              dl_err,
  output logic [ADDR_W:0]   dl_count,
  output logic [1:0]        dbg_state
);

  localparam int CW = ADDR_W + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {BOOT = 2'd0, LOAD = 2'd1, SETTLE = 2'd2, RUN = 2'd3} state_t;

  state_t          state;
  logic            dl_prev;
  logic [HW-1:0]   hold;
  logic            rd_pend;
  logic            rise;
  logic            fall;
  logic            wr_ok;
  logic            wr_bad;
  logic [CW-1:0]   cnt_inc;
  logic [CW-1:0]   cnt_next;

  // Handshake: ioctl_wr and core_rd are single-cycle strobes with no back-pressure;
  // core_valid is a single-cycle strobe qualifying core_data, two cycles after core_rd.
  assign rise     = ioctl_download & ~dl_prev;
  assign fall     = ~ioctl_download & dl_prev;
  assign wr_ok    = (state == LOAD) && ioctl_wr && (ioctl_addr < 25'(ROM_BYTES));
  assign wr_bad   = (state == LOAD) && ioctl_wr && !(ioctl_addr < 25'(ROM_BYTES));
  assign cnt_inc  = (dl_count == {CW{1'b1}}) ? dl_count : dl_count + 1'b1;
  assign cnt_next = wr_ok ? cnt_inc : dl_count;

  // The RAM output register already supplies the second pipeline stage.
  assign core_data = core_valid ? ram_dout : 8'h00;
  assign dbg_state = state;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state      <= BOOT;
      dl_prev    <= 1'b0;
      hold       <= '0;
      rd_pend    <= 1'b0;
      core_valid <= 1'b0;
      core_reset <= 1'b1;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= 8'h00;
      dl_err     <= 1'b0;
      dl_count   <= '0;
    end else begin
      dl_prev    <= ioctl_download;
      ram_we     <= 1'b0;
      rd_pend    <= 1'b0;
      core_valid <= rd_pend;
      case (state)
        BOOT: begin
          if (rise) begin
            state    <= LOAD;
            dl_count <= '0;
            dl_err   <= 1'b0;
          end
        end
        LOAD: begin
          dl_count <= cnt_next;
          if (wr_ok) begin
            ram_we   <= 1'b1;
            ram_addr <= ioctl_addr[ADDR_W-1:0];
            ram_din  <= ioctl_dout;
          end
          if (wr_bad) dl_err <= 1'b1;
          if (fall) begin
            state <= SETTLE;
            hold  <= HW'(HOLD_CYCLES - 1);
            if (cnt_next != CW'(ROM_BYTES)) dl_err <= 1'b1;
          end
        end
        SETTLE: begin
          if (rise) begin
            state    <= LOAD;
            dl_count <= '0;
            dl_err   <= 1'b0;
          end else if (hold == '0) begin
            state      <= RUN;
            core_reset <= 1'b0;
          end else begin
            hold <= hold - 1'b1;
          end
        end
        RUN: begin
          // A read sampled together with a reload still completes.
          if (core_rd) begin
            ram_addr <= core_addr;
            rd_pend  <= 1'b1;
          end
          if (rise) begin
            state      <= LOAD;
            core_reset <= 1'b1;
            dl_count   <= '0;
            dl_err     <= 1'b0;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_load_sched.sv
// Directed bench for rom_load_sched: download/settle/run sequencing, RAM write
// stream, pipelined core reads and reset release timing against a bench model.
module tb_rom_load_sched;

  localparam int AW   = 17;
  localparam int ROM  = 1024;
  localparam int HOLD = 4096;
  localparam int W    = AW + 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [24:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0;
  logic          core_rd = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [7:0]    core_data;
  logic          core_valid;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_din;
  logic [7:0]    ram_dout;
  logic          core_reset;
  logic          dl_err;
  logic [AW:0]   dl_count;
  logic [1:0]    dbg_state;

  rom_load_sched #(.ADDR_W(AW), .ROM_BYTES(ROM), .HOLD_CYCLES(HOLD)) dut (
    .clk_sys(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .core_rd(core_rd), .core_addr(core_addr), .core_data(core_data),
    .core_valid(core_valid), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_din(ram_din), .ram_dout(ram_dout), .core_reset(core_reset),
    .dl_err(dl_err), .dl_count(dl_count), .dbg_state(dbg_state)
  );

  // clock / reset block and external RAM (registered read, 1-cycle latency)
  always #5 clk = ~clk;

  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // model state: shadow image, expected write stream, expected reads, reset release
  logic [7:0]   shadow [0:(1<<AW)-1];
  logic [W-1:0] exp_q[$];
  int           exp_rc[$];
  logic [7:0]   exp_r[$];
  bit           rel_en = 1'b0;
  int           rel_cyc = 0;
  logic [7:0]   last_rd = 8'h00;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // compare process: every cycle, 1 time unit after the rising edge
  always @(posedge clk) begin
    #1;
    check("core_reset", {31'd0, core_reset}, {31'd0, !(rel_en && cyc >= rel_cyc)});
    if (ram_we) begin
      if (exp_q.size() == 0) check("ram_we_unexpected", {31'd0, ram_we}, 32'd0);
      else check("ram_write", 32'({ram_addr, ram_din}), 32'(exp_q.pop_front()));
    end
    if (core_valid) begin
      if (exp_r.size() == 0) check("core_valid_unexpected", {31'd0, core_valid}, 32'd0);
      else begin
        check("read_cycle", 32'(cyc), 32'(exp_rc.pop_front()));
        last_rd = core_data;
        check("read_data", {24'd0, core_data}, {24'd0, exp_r.pop_front()});
      end
    end else if (exp_rc.size() > 0 && cyc >= exp_rc[0]) begin
      check("read_missing", {31'd0, core_valid}, 32'd1);
      void'(exp_rc.pop_front());
      void'(exp_r.pop_front());
    end
  end

  // driver tasks (inputs change on the falling edge)
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic download(input int n, input logic [7:0] seed, input bit extra,
                          input bit coincide, input bit already);
    if (!already) begin
      ioctl_download = 1'b1;
      rel_en = 1'b0;
      @(negedge clk);
    end
    for (int a = 0; a < n; a++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(a);
      ioctl_dout = 8'(a) ^ seed;
      shadow[a]  = ioctl_dout;
      exp_q.push_back({AW'(a), ioctl_dout});
      if (coincide && a == n - 1) begin
        ioctl_download = 1'b0;
        rel_cyc = cyc + 1 + HOLD;
        rel_en = 1'b1;
      end
      @(negedge clk);
    end
    ioctl_wr = 1'b0;
    if (extra) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(ROM);
      ioctl_dout = 8'hEE;
      @(negedge clk);
      ioctl_wr = 1'b0;
    end
    if (!coincide) begin
      ioctl_download = 1'b0;
      rel_cyc = cyc + 1 + HOLD;
      rel_en = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic rd(input logic [AW-1:0] a);
    core_rd   = 1'b1;
    core_addr = a;
    exp_rc.push_back(cyc + 2);
    exp_r.push_back(shadow[a]);
    @(negedge clk);
    core_rd = 1'b0;
  endtask

  task automatic wait_run();
    int k = 0;
    while (core_reset && k < HOLD + 20) begin
      @(negedge clk);
      k++;
    end
    check("run_reached", {31'd0, core_reset}, 32'd0);
  endtask

  initial begin
    // reset values and idle behaviour
    tick(3);
    check("rst_core_reset", {31'd0, core_reset}, 32'd1);
    check("rst_core_valid", {31'd0, core_valid}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_dl_err", {31'd0, dl_err}, 32'd0);
    check("rst_dl_count", 32'(dl_count), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_din", {24'd0, ram_din}, 32'd0);
    check("rst_core_data", {24'd0, core_data}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      core_rd   = (i % 7 == 0);
      core_addr = AW'(i);
      @(negedge clk);
    end
    core_rd = 1'b0;
    check("idle_state", {30'd0, dbg_state}, 32'd0);

    // full download, settle, release
    download(ROM, 8'h5A, 1'b0, 1'b0, 1'b0);
    tick(1);
    check("full_count", 32'(dl_count), 32'd1024);
    check("full_err", {31'd0, dl_err}, 32'd0);
    check("full_writes_done", 32'(exp_q.size()), 32'd0);
    wait_run();

    // pipelined reads, plus a stray ioctl_wr outside LOAD
    rd(AW'('h10));
    rd(AW'('h11));
    ioctl_wr = 1'b1; ioctl_addr = 25'h5; ioctl_dout = 8'h99;
    tick(1);
    ioctl_wr = 1'b0;
    tick(3);
    check("shadow_pin", {24'd0, shadow[16]}, 32'h4A);
    check("last_read", {24'd0, last_rd}, 32'h4B);
    rd(AW'(ROM - 1));
    rd(AW'('h0));
    tick(4);
    check("run_reads_done", 32'(exp_r.size()), 32'd0);

    // reload from RUN with a read sampled on the rise, plus an out-of-range write
    core_rd = 1'b1; core_addr = AW'('h20);
    exp_rc.push_back(cyc + 2); exp_r.push_back(shadow[32]);
    ioctl_download = 1'b1; rel_en = 1'b0;
    @(negedge clk);
    core_rd = 1'b0;
    check("reload_state", {30'd0, dbg_state}, 32'd1);
    check("reload_count_clr", 32'(dl_count), 32'd0);
    download(ROM, 8'hA5, 1'b1, 1'b0, 1'b1);
    tick(1);
    check("ovf_err", {31'd0, dl_err}, 32'd1);
    check("ovf_count", 32'(dl_count), 32'd1024);
    check("ovf_writes_done", 32'(exp_q.size()), 32'd0);
    wait_run();
    rd(AW'('h33));
    tick(4);

    // short download, then abort 10 cycles into settle
    download(100, 8'h3C, 1'b0, 1'b0, 1'b0);
    tick(9);
    check("short_count", 32'(dl_count), 32'd100);
    check("short_err", {31'd0, dl_err}, 32'd1);
    check("short_settle", {30'd0, dbg_state}, 32'd2);
    ioctl_download = 1'b1; rel_en = 1'b0;
    @(negedge clk);
    check("abort_state", {30'd0, dbg_state}, 32'd1);
    check("abort_count", 32'(dl_count), 32'd0);
    check("abort_err", {31'd0, dl_err}, 32'd0);

    // last write coincident with the fall
    download(ROM, 8'hC3, 1'b0, 1'b1, 1'b1);
    tick(1);
    check("coin_count", 32'(dl_count), 32'd1024);
    check("coin_err", {31'd0, dl_err}, 32'd0);
    check("coin_writes_done", 32'(exp_q.size()), 32'd0);
    wait_run();
    rd(AW'(ROM - 1));
    rd(AW'('h7));
    tick(4);
    check("coin_last_read", {24'd0, last_rd}, {24'd0, 8'h07 ^ 8'hC3});

    // reset during LOAD, with a write on the reset cycle
    ioctl_download = 1'b1; rel_en = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 2; a++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(a); ioctl_dout = 8'h11 + 8'(a);
      shadow[a] = ioctl_dout;
      exp_q.push_back({AW'(a), ioctl_dout});
      @(negedge clk);
    end
    ioctl_addr = 25'h2; ioctl_dout = 8'h77;
    reset_n = 1'b0; ioctl_download = 1'b0;
    @(negedge clk);
    ioctl_wr = 1'b0;
    check("mid_rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("mid_rst_core_reset", {31'd0, core_reset}, 32'd1);
    check("mid_rst_valid", {31'd0, core_valid}, 32'd0);
    check("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    reset_n = 1'b1;
    tick(5);
    check("end_state", {30'd0, dbg_state}, 32'd0);
    check("end_writes_done", 32'(exp_q.size()), 32'd0);
    check("end_reads_done", 32'(exp_r.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
